ecc_scrub_sched: RTL and testbench
==================================

// Module: ecc_scrub_sched
// PURPOSE
// - Schedules the ECC scrubber of one cache data/tag bank.
// - Paces scrub steps with a programmable inter-step interval.
// - Prevents starvation of the scrubber by host traffic; forces one scrub slot after MaxStall blocked cycles.
// - Keeps saturating corrected/uncorrectable counters and a sticky uncorrectable IRQ.
// - Sits between the cache controller/CSR block and the scrubber; its trigger drives the scrubber trigger input.
// PARAMETERS
// BankSize       256  lines per bank (scrubber address range)
// SetAssoc       2    ways per line; one scrub step = one way of one line
// IntervalWidth  16   width of interval_i
// MaxStall       64   SCRUB cycles with host_req_i high before host is stalled (>=1)
// CntWidth       16   width of error counters
// PORTS
// clk_i             in   1              clock
// rst_ni            in   1              async active-low reset
// enable_i          in   1              scrubbing enabled (level)
// interval_i        in   IntervalWidth  idle cycles between steps; sampled on WAIT entry
// clear_i           in   1              clear counters and irq (pulse)
// host_req_i        in   1              OR of host requests to the bank
// step_done_i       in   1              scrubber finished one step (pulse)
// corrected_i       in   1              scrubber corrected a bit (pulse)
// uncorrectable_i   in   1              scrubber found uncorrectable error (pulse)
// scrub_trigger_o   out  1              enable to scrubber
// host_stall_o      out  1              block host requests this cycle
// sweep_done_o      out  1              pulse: full bank swept
// corr_cnt_o        out  CntWidth       corrected-error count (saturating)
// uncorr_cnt_o      out  CntWidth       uncorrectable count (saturating)
// uncorr_irq_o      out  1              sticky, set by uncorrectable_i
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; wait, stall and step counters 0.
// - All outputs are registered or decoded from registered state only; no input->output comb path.
// - IDLE: trigger=0.
//   - enable_i=1 -> WAIT; load wait_cnt=interval_i.
// - WAIT: trigger=0.
//   - enable_i=0 -> IDLE, checked before the count.
//   - wait_cnt==0 -> SCRUB; otherwise decrement.
//   - interval_i=0: one WAIT cycle, then SCRUB.
// - SCRUB: trigger=1.
//   - step_done_i -> WAIT: reload wait_cnt, clear stall_cnt; goes to IDLE instead if enable_i=0.
//   - Else if host_req_i, stall_cnt++; when stall_cnt reaches MaxStall-1 while host_req_i, next state FORCE.
//   - stall_cnt is not cleared by host_req_i=0; it clears only on leaving SCRUB/FORCE.
// - FORCE: trigger=1, host_stall_o=1.
//   - step_done_i -> WAIT, or IDLE if enable_i=0.
//   - Host stalled for at most until the step ends.
// - enable_i drop in SCRUB/FORCE never aborts a step; the step completes first.
// - step_done_i is ignored in IDLE/WAIT.
// - Step counter 0..BankSize*SetAssoc-1, +1 per accepted step_done_i; wraps to 0.
//   - sweep_done_o pulses 1 cycle after the wrap step.
//   - Step counter is not reset by enable_i.
// - Counters:
//   - corrected_i/uncorrectable_i are counted in any state, +1 per pulse, saturating at all-ones.
//   - clear_i zeroes both counters and irq.
//   - clear_i and an event in the same cycle: counter=1, irq=1 (event wins over clear).
// - uncorr_irq_o is set the cycle after uncorrectable_i and held until clear_i.
// - Async reset mid-step drops trigger/stall immediately; counters are lost.
// TESTING
// - interval_i=3, enable_i=1, step_done_i 2 cycles after each trigger -> trigger rises 5 cycles after enable; steps spaced 3+1 idle cycles.
// - MaxStall=4, host_req_i held high in SCRUB -> host_stall_o=1 from 5th SCRUB cycle until step_done_i; then 0.
// - BankSize=4, SetAssoc=2, interval 0 -> sweep_done_o pulses after the 8th step_done_i and again after the 16th.
// - CntWidth=2: 5 corrected_i pulses -> corr_cnt_o=3; clear_i together with corrected_i -> corr_cnt_o=1.
// - uncorrectable_i pulse -> irq=1 and uncorr_cnt_o=1; clear_i -> both 0.
// - enable_i dropped while in SCRUB -> trigger stays 1 until step_done_i, then IDLE; reset asserted in FORCE -> all outputs 0 immediately.

Source files
------------

// File: rtl/ecc_scrub_sched.sv
// Scrub scheduler for one cache bank: paces scrubber steps, forces a scrub slot
// when host traffic starves the scrubber, and keeps error counters and a sticky IRQ.
module ecc_scrub_sched #(
    parameter int BankSize      = 256,
    parameter int SetAssoc      = 2,
    parameter int IntervalWidth = 16,
    parameter int MaxStall      = 64,
    parameter int CntWidth      = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [IntervalWidth-1:0] interval_i,
    input  logic                     clear_i,
    input  logic                     host_req_i,
    input  logic                     step_done_i,
    input  logic                     corrected_i,
    input  logic                     uncorrectable_i,
    output logic                     scrub_trigger_o,
    output logic                     host_stall_o,
    output logic                     sweep_done_o,
    output logic [CntWidth-1:0]      corr_cnt_o,
    output logic [CntWidth-1:0]      uncorr_cnt_o,
    output logic                     uncorr_irq_o
);

    // state | meaning
    // IDLE  | scrubbing disabled, trigger low
    // WAIT  | counting down the inter-step interval
    // SCRUB | step in progress, host traffic may still win arbitration
    // FORCE | step in progress, host stalled until the step ends

    localparam int Steps  = BankSize * SetAssoc;
    localparam int StepW  = (Steps > 1) ? $clog2(Steps) : 1;
    localparam int StallW = $clog2(MaxStall + 1);
    localparam logic [StepW-1:0]  LastStep  = StepW'(Steps - 1);
    localparam logic [StallW-1:0] StallLast = StallW'(MaxStall - 1);

    typedef enum logic [1:0] {IDLE, WAIT, SCRUB, FORCE} state_t;

    state_t                   state_q, state_d;
    logic [IntervalWidth-1:0] wait_cnt_q, wait_cnt_d;
    logic [StallW-1:0]        stall_cnt_q, stall_cnt_d;
    logic [StepW-1:0]         step_cnt_q;
    logic                     step_accept;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        step_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d    = WAIT;
                    wait_cnt_d = interval_i;
                end
            end
            WAIT: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == '0) begin
                    state_d = SCRUB;
                end else begin
                    wait_cnt_d = wait_cnt_q - IntervalWidth'(1);
                end
            end
            SCRUB, FORCE: begin
                if (step_done_i) begin
                    step_accept = 1'b1;
                    stall_cnt_d = '0;
                    if (enable_i) begin
                        state_d    = WAIT;
                        wait_cnt_d = interval_i;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (state_q == SCRUB && host_req_i) begin
                    // The MaxStall-th blocked cycle hands the next slot to the scrubber.
                    if (stall_cnt_q == StallLast) begin
                        state_d = FORCE;
                    end else begin
                        stall_cnt_d = stall_cnt_q + StallW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign scrub_trigger_o = (state_q == SCRUB) || (state_q == FORCE);
    assign host_stall_o    = (state_q == FORCE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            step_cnt_q   <= '0;
            sweep_done_o <= 1'b0;
        end else begin
            sweep_done_o <= 1'b0;
            if (step_accept) begin
                if (step_cnt_q == LastStep) begin
                    step_cnt_q   <= '0;
                    sweep_done_o <= 1'b1;
                end else begin
                    step_cnt_q <= step_cnt_q + StepW'(1);
                end
            end
        end
    end

    // A new event in the same cycle as clear_i survives the clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            corr_cnt_o   <= '0;
            uncorr_cnt_o <= '0;
            uncorr_irq_o <= 1'b0;
        end else begin
            if (clear_i) begin
                corr_cnt_o   <= CntWidth'(corrected_i);
                uncorr_cnt_o <= CntWidth'(uncorrectable_i);
            end else begin
                if (corrected_i && (corr_cnt_o != '1)) begin
                    corr_cnt_o <= corr_cnt_o + CntWidth'(1);
                end
                if (uncorrectable_i && (uncorr_cnt_o != '1)) begin
                    uncorr_cnt_o <= uncorr_cnt_o + CntWidth'(1);
                end
            end
            if (uncorrectable_i) begin
                uncorr_irq_o <= 1'b1;
            end else if (clear_i) begin
                uncorr_irq_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ecc_scrub_sched.sv
// Bench for ecc_scrub_sched: event-timing scoreboard for trigger/stall/sweep plus
// direct counter and reset checks.
module tb_ecc_scrub_sched;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] interval = '0;
    logic        clear = 1'b0;
    logic        host_req = 1'b0;
    logic        step_done = 1'b0;
    logic        corrected = 1'b0;
    logic        uncorr = 1'b0;
    logic        trigger, host_stall, sweep_done, irq;
    logic [1:0]  corr_cnt, uncorr_cnt;

    ecc_scrub_sched #(
        .BankSize(4), .SetAssoc(2), .IntervalWidth(16), .MaxStall(4), .CntWidth(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable), .interval_i(interval),
        .clear_i(clear), .host_req_i(host_req), .step_done_i(step_done),
        .corrected_i(corrected), .uncorrectable_i(uncorr),
        .scrub_trigger_o(trigger), .host_stall_o(host_stall), .sweep_done_o(sweep_done),
        .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt), .uncorr_irq_o(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int steps_issued = 0;
    bit trig_mon = 1'b0;
    bit stall_mon = 1'b0;
    int exp_trig[$];
    int exp_stall[$];
    int exp_sweep[$];
    logic trig_q = 1'b0;
    logic stall_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (trig_mon && trigger && !trig_q) begin
            if (exp_trig.size() == 0) check("trig_unexpected_rise", cyc, -1);
            else check("trig_rise_cycle", cyc, exp_trig.pop_front());
        end
        if (stall_mon && host_stall && !stall_q) begin
            if (exp_stall.size() == 0) check("stall_unexpected_rise", cyc, -1);
            else check("stall_rise_cycle", cyc, exp_stall.pop_front());
        end
        if (sweep_done) begin
            if (exp_sweep.size() == 0) check("sweep_unexpected", steps_issued, -1);
            else check("sweep_at_step", steps_issued, exp_sweep.pop_front());
        end
        trig_q  <= trigger;
        stall_q <= host_stall;
    end

    task automatic do_reset();
        enable = 0; clear = 0; host_req = 0; step_done = 0; corrected = 0; uncorr = 0;
        rst_ni = 0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1;
    endtask

    task automatic wait_trigger();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (trigger) return;
        end
        check("trig_timeout", trigger, 1);
    endtask

    task automatic pulse_step(input bit counted);
        @(posedge clk);
        #1 step_done = 1;
        if (counted) steps_issued++;
        @(posedge clk);
        #1 step_done = 0;
    endtask

    task automatic pulse_evt(input bit c, input bit u, input bit clr);
        @(posedge clk);
        #1 corrected = c; uncorr = u; clear = clr;
        @(posedge clk);
        #1 corrected = 0; uncorr = 0; clear = 0;
    endtask

    int c0, t;

    initial begin
        do_reset();
        check("rst_trigger", trigger, 0);
        check("rst_stall", host_stall, 0);
        check("rst_sweep", sweep_done, 0);
        check("rst_corr", corr_cnt, 0);
        check("rst_uncorr", uncorr_cnt, 0);
        check("rst_irq", irq, 0);

        // pacing: interval 3, step ends two cycles after trigger
        trig_mon = 1;
        interval = 16'd3;
        enable = 1;
        c0 = cyc;
        exp_trig.push_back(c0 + 5);
        exp_trig.push_back(c0 + 11);
        exp_trig.push_back(c0 + 17);
        for (int i = 0; i < 3; i++) begin
            wait_trigger();
            pulse_step(1'b1);
        end
        enable = 0;
        repeat (10) @(negedge clk);
        check("idle_no_trigger", trigger, 0);
        trig_mon = 0;

        // sweep: 8 steps per bank, step_done ignored while idle
        do_reset();
        steps_issued = 0;
        repeat (3) pulse_step(1'b0);
        interval = 16'd0;
        enable = 1;
        exp_sweep.push_back(8);
        exp_sweep.push_back(16);
        for (int i = 0; i < 16; i++) begin
            wait_trigger();
            pulse_step(1'b1);
        end
        repeat (3) @(negedge clk);
        enable = 0;

        // starvation guard
        do_reset();
        stall_mon = 1;
        interval = 16'd0;
        host_req = 1;
        enable = 1;
        wait_trigger();
        t = cyc;
        exp_stall.push_back(t + 4);
        repeat (5) @(negedge clk);
        check("stall_held", host_stall, 1);
        pulse_step(1'b1);
        check("stall_released", host_stall, 0);
        check("trig_after_forced_step", trigger, 0);
        wait_trigger();
        t = cyc;
        exp_stall.push_back(t + 5);
        @(negedge clk);
        @(negedge clk);
        host_req = 0;
        @(negedge clk);
        host_req = 1;
        repeat (3) @(negedge clk);
        enable = 0;
        repeat (2) @(negedge clk);
        check("drop_enable_trig_held", trigger, 1);
        check("drop_enable_stall_held", host_stall, 1);
        pulse_step(1'b1);
        check("drop_enable_trig_off", trigger, 0);
        check("drop_enable_stall_off", host_stall, 0);
        repeat (5) @(negedge clk);
        check("drop_enable_idle", trigger, 0);
        stall_mon = 0;
        host_req = 0;

        // saturating counters and sticky irq
        repeat (5) pulse_evt(1'b1, 1'b0, 1'b0);
        check("corr_saturate", corr_cnt, 3);
        check("uncorr_untouched", uncorr_cnt, 0);
        pulse_evt(1'b1, 1'b0, 1'b1);
        check("corr_clear_with_event", corr_cnt, 1);
        check("irq_before_event", irq, 0);
        pulse_evt(1'b0, 1'b1, 1'b0);
        check("irq_set", irq, 1);
        check("uncorr_one", uncorr_cnt, 1);
        pulse_evt(1'b0, 1'b0, 1'b1);
        check("uncorr_cleared", uncorr_cnt, 0);
        check("irq_cleared", irq, 0);
        check("corr_cleared", corr_cnt, 0);
        pulse_evt(1'b0, 1'b1, 1'b1);
        check("uncorr_clear_with_event", uncorr_cnt, 1);
        check("irq_clear_with_event", irq, 1);

        // async reset while host is stalled
        interval = 16'd0;
        host_req = 1;
        enable = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (host_stall) break;
        end
        check("force_reached", host_stall, 1);
        #2 rst_ni = 0;
        #1;
        check("arst_trigger", trigger, 0);
        check("arst_stall", host_stall, 0);
        check("arst_sweep", sweep_done, 0);
        check("arst_corr", corr_cnt, 0);
        check("arst_uncorr", uncorr_cnt, 0);
        check("arst_irq", irq, 0);

        check("trig_queue_left", exp_trig.size(), 0);
        check("stall_queue_left", exp_stall.size(), 0);
        check("sweep_queue_left", exp_sweep.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
